// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone B3 arbiter: 3 masters share one memory slave.
// Grant is held for a whole cyc; a watchdog errors out stalled accesses.
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, async active-low reset
//   m_*_i / m_*_o                three masters, master n at slice n
//   s_*_o / s_*_i                single slave request / response
//   grant_o                      one-hot registered grant, 0 when idle
module wb_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic [3*AW-1:0]       m_adr_i,
  input  logic [3*DW-1:0]       m_dat_i,
  input  logic [3*(DW/8)-1:0]   m_sel_i,
  input  logic [2:0]            m_we_i,
  input  logic [2:0]            m_cyc_i,
  input  logic [2:0]            m_stb_i,
  input  logic [8:0]            m_cti_i,
  input  logic [5:0]            m_bte_i,
  output logic [DW-1:0]         m_dat_o,
  output logic [2:0]            m_ack_o,
  output logic [2:0]            m_err_o,
  output logic [2:0]            m_rty_o,
  output logic [AW-1:0]         s_adr_o,
  output logic [DW-1:0]         s_dat_o,
  output logic [DW/8-1:0]       s_sel_o,
  output logic                  s_we_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic [2:0]            s_cti_o,
  output logic [1:0]            s_bte_o,
  input  logic [DW-1:0]         s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  output logic [2:0]            grant_o
);

  localparam int SW = DW / 8;
  localparam logic [15:0] TO = 16'(TIMEOUT);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e      state_q;
  logic [2:0]  grant_q;
  logic [1:0]  last_q;
  logic [15:0] wdog_q;
  logic [15:0] wdog_d;

  logic        busy;
  logic [1:0]  nx1;
  logic [1:0]  nx2;
  logic [1:0]  win_idx;
  logic [2:0]  win_oh;
  logic        cyc_g;
  logic        stb_g;
  logic        term;
  logic        wd_fire;

  assign busy    = (state_q == BUSY);
  assign grant_o = grant_q;
  assign term    = s_ack_i | s_err_i | s_rty_i;

  // Search order last+1, last+2, last (mod 3).
  always_comb begin
    nx1 = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    nx2 = (nx1 == 2'd2) ? 2'd0 : nx1 + 2'd1;
    win_idx = last_q;
    if (m_cyc_i[nx1]) begin
      win_idx = nx1;
    end else if (m_cyc_i[nx2]) begin
      win_idx = nx2;
    end
    win_oh = 3'b001 << win_idx;
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    cyc_g   = 1'b0;
    stb_g   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (grant_q[i]) begin
        s_adr_o = m_adr_i[i*AW +: AW];
        s_dat_o = m_dat_i[i*DW +: DW];
        s_sel_o = m_sel_i[i*SW +: SW];
        s_we_o  = m_we_i[i];
        s_cti_o = m_cti_i[i*3 +: 3];
        s_bte_o = m_bte_i[i*2 +: 2];
        cyc_g   = m_cyc_i[i];
        stb_g   = m_stb_i[i];
      end
    end
  end

  // A real slave termination beats the watchdog in the same cycle.
  assign wd_fire = busy & stb_g & (wdog_q == TO) & ~term;

  assign s_cyc_o = cyc_g;
  assign s_stb_o = stb_g & ~wd_fire;

  assign m_dat_o = busy ? s_dat_i : '0;
  assign m_ack_o = grant_q & {3{s_ack_i}};
  assign m_err_o = grant_q & {3{s_err_i | wd_fire}};
  assign m_rty_o = grant_q & {3{s_rty_i}};

  always_comb begin
    wdog_d = wdog_q;
    if (!busy || !s_stb_o || term) begin
      wdog_d = '0;
    end else if (wdog_q != TO) begin
      wdog_d = wdog_q + 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 2'd2;
      wdog_q  <= '0;
    end else begin
      wdog_q <= wdog_d;
      unique case (state_q)
        IDLE: begin
          if (|m_cyc_i) begin
            grant_q <= win_oh;
            last_q  <= win_idx;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!cyc_g) begin
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
